// File: rtl/execute_stage.sv
// Purpose: EX stage of the 5-stage MIPS pipeline; ALU, branch target, destination select, EX/MEM latch.
// Latency: combinational EX logic, one cycle into the EX/MEM latch, one instruction per cycle.
// Backpressure: stall holds the whole latch; flush (wins over stall) turns the latch into a bubble.
//
// Ports:
//   clk, rst (async active-low)   - pipeline clock and reset
//   stall, flush                  - EX/MEM latch hold / bubble insert
//   id_ex_*                       - ID/EX latch contents from decode
//   ex_mem_*                      - registered EX/MEM latch contents
// Optional build macro EX_FORWARD_EN adds forward_a, forward_b and mem_wb_write_data
// for operand forwarding from the EX/MEM and MEM/WB stages.
module execute_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic [1:0]    id_ex_wb,
    input  logic [2:0]    id_ex_mem,
    input  logic [3:0]    id_ex_execute,
    input  logic [DW-1:0] id_ex_npc,
    input  logic [DW-1:0] id_ex_readdat1,
    input  logic [DW-1:0] id_ex_readdat2,
    input  logic [DW-1:0] id_ex_sign_ext,
    input  logic [RW-1:0] id_ex_instr_bits_20_16,
    input  logic [RW-1:0] id_ex_instr_bits_15_11,
    output logic [1:0]    ex_mem_wb,
    output logic [2:0]    ex_mem_mem,
    output logic [DW-1:0] ex_mem_add_result,
    output logic          ex_mem_zero,
    output logic [DW-1:0] ex_mem_alu_result,
    output logic [DW-1:0] ex_mem_rdata2,
    output logic [RW-1:0] ex_mem_muxout,
    output logic          ex_mem_valid
`ifdef EX_FORWARD_EN
    ,
    input  logic [1:0]    forward_a,
    input  logic [1:0]    forward_b,
    input  logic [DW-1:0] mem_wb_write_data
`endif
);

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_NONE
    } alu_fn_t;

    logic          regdst;
    logic [1:0]    aluop;
    logic          alusrc;
    logic [5:0]    funct;
    alu_fn_t       alu_fn;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_rt;      // rt operand after forwarding; also the store data
    logic [DW-1:0] op_b;
    logic [DW-1:0] alu_res;
    logic [DW-1:0] add_res;
    logic [RW-1:0] dst_reg;

    assign regdst = id_ex_execute[3];
    assign aluop  = id_ex_execute[2:1];
    assign alusrc = id_ex_execute[0];
    assign funct  = id_ex_sign_ext[5:0];

`ifdef EX_FORWARD_EN
    // 10 = previous instruction (EX/MEM), 01 = two back (MEM/WB); 11 falls to the ID/EX value.
    always_comb begin
        case (forward_a)
            2'b10:   op_a = ex_mem_alu_result;
            2'b01:   op_a = mem_wb_write_data;
            default: op_a = id_ex_readdat1;
        endcase
    end

    always_comb begin
        case (forward_b)
            2'b10:   op_rt = ex_mem_alu_result;
            2'b01:   op_rt = mem_wb_write_data;
            default: op_rt = id_ex_readdat2;
        endcase
    end
`else
    assign op_a  = id_ex_readdat1;
    assign op_rt = id_ex_readdat2;
`endif

    assign op_b = alusrc ? id_ex_sign_ext : op_rt;

    // ALU control: 10 defers to the funct field, 11 is the immediate-logical OR.
    always_comb begin
        alu_fn = ALU_NONE;
        case (aluop)
            2'b00: alu_fn = ALU_ADD;
            2'b01: alu_fn = ALU_SUB;
            2'b11: alu_fn = ALU_OR;
            default: begin
                case (funct)
                    6'b100000: alu_fn = ALU_ADD;
                    6'b100010: alu_fn = ALU_SUB;
                    6'b100100: alu_fn = ALU_AND;
                    6'b100101: alu_fn = ALU_OR;
                    6'b101010: alu_fn = ALU_SLT;
                    default:   alu_fn = ALU_NONE;
                endcase
            end
        endcase
    end

    // Add/sub wrap silently; slt compares as signed and zero-extends the flag.
    always_comb begin
        alu_res = '0;
        case (alu_fn)
            ALU_ADD: alu_res = op_a + op_b;
            ALU_SUB: alu_res = op_a - op_b;
            ALU_AND: alu_res = op_a & op_b;
            ALU_OR:  alu_res = op_a | op_b;
            ALU_SLT: alu_res = {{(DW-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            default: alu_res = '0;
        endcase
    end

    assign add_res = id_ex_npc + (id_ex_sign_ext << 2);
    assign dst_reg = regdst ? id_ex_instr_bits_15_11 : id_ex_instr_bits_20_16;

    // A flush only kills the control fields and valid; data fields keep their old values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_mem_wb         <= '0;
            ex_mem_mem        <= '0;
            ex_mem_add_result <= '0;
            ex_mem_zero       <= 1'b0;
            ex_mem_alu_result <= '0;
            ex_mem_rdata2     <= '0;
            ex_mem_muxout     <= '0;
            ex_mem_valid      <= 1'b0;
        end else if (flush) begin
            ex_mem_wb    <= '0;
            ex_mem_mem   <= '0;
            ex_mem_valid <= 1'b0;
        end else if (!stall) begin
            ex_mem_wb         <= id_ex_wb;
            ex_mem_mem        <= id_ex_mem;
            ex_mem_add_result <= add_res;
            ex_mem_zero       <= (alu_res == '0);
            ex_mem_alu_result <= alu_res;
            ex_mem_rdata2     <= op_rt;
            ex_mem_muxout     <= dst_reg;
            ex_mem_valid      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Purpose: directed self-checking bench for execute_stage.
// Latency: inputs driven after each rising edge, results read 1 time unit after the capturing edge.
// Backpressure: stall/flush are exercised directly as directed steps.
module tb_execute_stage;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk;
    logic          rst;
    logic          stall;
    logic          flush;
    logic [1:0]    id_ex_wb;
    logic [2:0]    id_ex_mem;
    logic [3:0]    id_ex_execute;
    logic [DW-1:0] id_ex_npc;
    logic [DW-1:0] id_ex_readdat1;
    logic [DW-1:0] id_ex_readdat2;
    logic [DW-1:0] id_ex_sign_ext;
    logic [RW-1:0] id_ex_instr_bits_20_16;
    logic [RW-1:0] id_ex_instr_bits_15_11;
    logic [1:0]    ex_mem_wb;
    logic [2:0]    ex_mem_mem;
    logic [DW-1:0] ex_mem_add_result;
    logic          ex_mem_zero;
    logic [DW-1:0] ex_mem_alu_result;
    logic [DW-1:0] ex_mem_rdata2;
    logic [RW-1:0] ex_mem_muxout;
    logic          ex_mem_valid;
`ifdef EX_FORWARD_EN
    logic [1:0]    forward_a;
    logic [1:0]    forward_b;
    logic [DW-1:0] mem_wb_write_data;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    execute_stage #(.DW(DW), .RW(RW)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .stall                  (stall),
        .flush                  (flush),
        .id_ex_wb               (id_ex_wb),
        .id_ex_mem              (id_ex_mem),
        .id_ex_execute          (id_ex_execute),
        .id_ex_npc              (id_ex_npc),
        .id_ex_readdat1         (id_ex_readdat1),
        .id_ex_readdat2         (id_ex_readdat2),
        .id_ex_sign_ext         (id_ex_sign_ext),
        .id_ex_instr_bits_20_16 (id_ex_instr_bits_20_16),
        .id_ex_instr_bits_15_11 (id_ex_instr_bits_15_11),
        .ex_mem_wb              (ex_mem_wb),
        .ex_mem_mem             (ex_mem_mem),
        .ex_mem_add_result      (ex_mem_add_result),
        .ex_mem_zero            (ex_mem_zero),
        .ex_mem_alu_result      (ex_mem_alu_result),
        .ex_mem_rdata2          (ex_mem_rdata2),
        .ex_mem_muxout          (ex_mem_muxout),
        .ex_mem_valid           (ex_mem_valid)
`ifdef EX_FORWARD_EN
        ,
        .forward_a              (forward_a),
        .forward_b              (forward_b),
        .mem_wb_write_data      (mem_wb_write_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // execute = {regdst, aluop[1:0], alusrc}
    task automatic drive(input logic [1:0] wb, input logic [2:0] mem, input logic [3:0] exe,
                         input logic [31:0] npc, input logic [31:0] rd1, input logic [31:0] rd2,
                         input logic [31:0] sext, input logic [4:0] rt, input logic [4:0] rd);
        id_ex_wb               = wb;
        id_ex_mem              = mem;
        id_ex_execute          = exe;
        id_ex_npc              = npc;
        id_ex_readdat1         = rd1;
        id_ex_readdat2         = rd2;
        id_ex_sign_ext         = sext;
        id_ex_instr_bits_20_16 = rt;
        id_ex_instr_bits_15_11 = rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wb"},    32'(ex_mem_wb),    32'h0);
        check({tag, "_mem"},   32'(ex_mem_mem),   32'h0);
        check({tag, "_add"},   ex_mem_add_result, 32'h0);
        check({tag, "_zero"},  32'(ex_mem_zero),  32'h0);
        check({tag, "_alu"},   ex_mem_alu_result, 32'h0);
        check({tag, "_rd2"},   ex_mem_rdata2,     32'h0);
        check({tag, "_mux"},   32'(ex_mem_muxout), 32'h0);
        check({tag, "_valid"}, 32'(ex_mem_valid), 32'h0);
    endtask

    initial begin
        rst   = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        drive(2'b00, 3'b000, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
`ifdef EX_FORWARD_EN
        forward_a = 2'b00;
        forward_b = 2'b00;
        mem_wb_write_data = 32'h0;
`endif
        #1;
        check_all_zero("reset");
        // Reset held across an edge keeps everything cleared.
        step();
        check_all_zero("reset_edge");

        // R-type add: 7 + 5, regdst picks rd=9.
        drive(2'b10, 3'b000, 4'b1100, 32'h104, 32'd7, 32'd5, 32'h20, 5'd3, 5'd9);
        #1 rst = 1'b1;
        step();
        check("add_alu",   ex_mem_alu_result, 32'd12);
        check("add_zero",  32'(ex_mem_zero), 32'h0);
        check("add_mux",   32'(ex_mem_muxout), 32'd9);
        check("add_valid", 32'(ex_mem_valid), 32'h1);
        check("add_wb",    32'(ex_mem_wb), 32'h2);
        check("add_rd2",   ex_mem_rdata2, 32'd5);
        check("add_tgt",   ex_mem_add_result, 32'h184);

        // R-type sub of equal operands -> zero flag.
        drive(2'b10, 3'b000, 4'b1100, 32'h108, 32'h1234, 32'h1234, 32'h22, 5'd4, 5'd10);
        step();
        check("sub_eq_alu",  ex_mem_alu_result, 32'h0);
        check("sub_eq_zero", 32'(ex_mem_zero), 32'h1);

        // aluop=01 sub 0-1 wraps; regdst=0 selects rt.
        drive(2'b00, 3'b100, 4'b0010, 32'h10C, 32'h0, 32'h1, 32'h0, 5'd6, 5'd11);
        step();
        check("sub_wrap_alu",  ex_mem_alu_result, 32'hFFFF_FFFF);
        check("sub_wrap_zero", 32'(ex_mem_zero), 32'h0);
        check("sub_wrap_mux",  32'(ex_mem_muxout), 32'd6);
        check("sub_wrap_mem",  32'(ex_mem_mem), 32'h4);

        // slt is signed: -1 < 1.
        drive(2'b10, 3'b000, 4'b1100, 32'h110, 32'hFFFF_FFFF, 32'h1, 32'h2A, 5'd1, 5'd2);
        step();
        check("slt_alu", ex_mem_alu_result, 32'h1);
        check("slt_tgt", ex_mem_add_result, 32'h1B8);

        // R-type and.
        drive(2'b10, 3'b000, 4'b1100, 32'h114, 32'h0000_F0F0, 32'h0000_FF00, 32'h24, 5'd1, 5'd2);
        step();
        check("and_alu", ex_mem_alu_result, 32'h0000_F000);

        // Unknown funct -> 0.
        drive(2'b10, 3'b000, 4'b1100, 32'h118, 32'h5, 32'h6, 32'h3F, 5'd1, 5'd2);
        step();
        check("badfn_alu",  ex_mem_alu_result, 32'h0);
        check("badfn_zero", 32'(ex_mem_zero), 32'h1);

        // Negative branch offset; alusrc=1 so ALU adds the immediate, rdata2 still rt.
        drive(2'b00, 3'b100, 4'b0001, 32'h100, 32'h10, 32'h55, 32'hFFFF_FFFE, 5'd7, 5'd8);
        step();
        check("br_tgt", ex_mem_add_result, 32'hF8);
        check("br_alu", ex_mem_alu_result, 32'hE);
        check("br_rd2", ex_mem_rdata2, 32'h55);

        // aluop=11 immediate OR.
        drive(2'b10, 3'b010, 4'b0111, 32'h120, 32'hF0, 32'h3, 32'h0F, 5'd12, 5'd13);
        step();
        check("ori_alu", ex_mem_alu_result, 32'hFF);
        check("ori_mux", 32'(ex_mem_muxout), 32'd12);

        // Stall three cycles while inputs keep changing.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(2'b01, 3'b001, 4'b1100, 32'h200 + 32'(i), 32'd100 + 32'(i), 32'd1, 32'h20, 5'd20, 5'd21);
            step();
            check("stall_alu",   ex_mem_alu_result, 32'hFF);
            check("stall_wb",    32'(ex_mem_wb), 32'h2);
            check("stall_mem",   32'(ex_mem_mem), 32'h2);
            check("stall_mux",   32'(ex_mem_muxout), 32'd12);
            check("stall_valid", 32'(ex_mem_valid), 32'h1);
        end

        // Flush wins over stall: controls cleared, data held.
        flush = 1'b1;
        step();
        check("flush_wb",    32'(ex_mem_wb), 32'h0);
        check("flush_mem",   32'(ex_mem_mem), 32'h0);
        check("flush_valid", 32'(ex_mem_valid), 32'h0);
        check("flush_alu",   ex_mem_alu_result, 32'hFF);

        // Release: the pending instruction (102 + 1) is captured.
        flush = 1'b0;
        stall = 1'b0;
        step();
        check("resume_alu",   ex_mem_alu_result, 32'd103);
        check("resume_valid", 32'(ex_mem_valid), 32'h1);
        check("resume_wb",    32'(ex_mem_wb), 32'h1);
        check("resume_mux",   32'(ex_mem_muxout), 32'd21);

`ifdef EX_FORWARD_EN
        // Dependent add: produce 12, then forward it as A with a stale rd1.
        drive(2'b10, 3'b000, 4'b1100, 32'h300, 32'd7, 32'd5, 32'h20, 5'd1, 5'd9);
        step();
        check("fwd_prev", ex_mem_alu_result, 32'd12);
        drive(2'b10, 3'b000, 4'b1100, 32'h304, 32'd0, 32'd3, 32'h20, 5'd1, 5'd10);
        forward_a = 2'b10;
        step();
        check("fwd_a_alu", ex_mem_alu_result, 32'd15);
        // Store with forwarded rt from MEM/WB.
        forward_a = 2'b00;
        forward_b = 2'b01;
        mem_wb_write_data = 32'hAB;
        drive(2'b00, 3'b001, 4'b0001, 32'h308, 32'h1000, 32'h0, 32'h4, 5'd2, 5'd0);
        step();
        check("fwd_b_rd2", ex_mem_rdata2, 32'hAB);
        check("fwd_b_alu", ex_mem_alu_result, 32'h1004);
        // Selector 11 behaves like 00.
        forward_a = 2'b11;
        forward_b = 2'b11;
        drive(2'b10, 3'b000, 4'b1100, 32'h30C, 32'd2, 32'd4, 32'h20, 5'd1, 5'd3);
        step();
        check("fwd_11_alu", ex_mem_alu_result, 32'd6);
        check("fwd_11_rd2", ex_mem_rdata2, 32'd4);
        forward_a = 2'b00;
        forward_b = 2'b00;
`endif

        // Async reset mid-cycle with nonzero outputs.
        drive(2'b11, 3'b111, 4'b1100, 32'h400, 32'd1, 32'd2, 32'h20, 5'd5, 5'd6);
        step();
        check("pre_rst_valid", 32'(ex_mem_valid), 32'h1);
        check("pre_rst_alu",   ex_mem_alu_result, 32'd3);
        #2 rst = 1'b0;
        #1;
        check_all_zero("async_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
